// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - command/response to APB master bridge with timeout
//
// Accepts one command at a time and runs it as a single APB transfer. The
// result comes back as one held response.
//
// Ports:
//   PCLK, PRESET                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready               command handshake; ready only in IDLE
//   cmd_write, cmd_addr, cmd_wdata    command direction, byte address, write data
//   rsp_valid/rsp_ready               response handshake; held until taken
//   rsp_rdata, rsp_err                read data (0 on write/error), error flag
//   PSEL, PENABLE, PWRITE, PADDR,     APB request (registered)
//   PWDATA
//   PRDATA, PREADY, PSLVERR           APB completer response
module apb_cmd_master #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  // Byte-lane bits that must be zero for an aligned access; none for 8-bit data.
  localparam int LSB = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 0;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);
  // Last wait count before giving up; reached after TIMEOUT stalled ACCESS cycles.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       aligned;

  assign cmd_ready = (state == IDLE);
  assign aligned   = ((cmd_addr & ALIGN_MASK) == '0);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (aligned) begin
              PADDR  <= cmd_addr;
              PWRITE <= cmd_write;
              PWDATA <= cmd_wdata;
              PSEL   <= 1'b1;
              state  <= SETUP;
            end else begin
              // Misaligned: answer with an error without touching the bus.
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          // PREADY wins over the timeout when both land in the same cycle.
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_rdata <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
            rsp_err   <= PSLVERR;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - scoreboard bench for apb_cmd_master
module tb_apb_cmd_master;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          PCLK, PRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  apb_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  int total = 0;
  int bad   = 0;

  logic [32:0] sb[$];

  int            wait_n = 0;
  logic [DW-1:0] slv_rdata = '0;
  logic          slv_err = 1'b0;
  logic [AW-1:0] exp_paddr = '0;
  logic          exp_pwrite = 1'b0;
  logic [DW-1:0] exp_pwdata = '0;
  int            psel_cnt = 0;
  int            pen_cnt = 0;
  int            stab_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // Completer model: PREADY rises after wait_n stalled ACCESS cycles.
  initial begin
    int acc;
    acc = 0;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    forever begin
      @(negedge PCLK);
      PRDATA  = slv_rdata;
      PSLVERR = slv_err;
      if (PSEL) begin
        psel_cnt++;
        if (PADDR !== exp_paddr || PWRITE !== exp_pwrite || PWDATA !== exp_pwdata)
          stab_cnt++;
      end
      if (PSEL && PENABLE) begin
        pen_cnt++;
        PREADY = (acc >= wait_n);
        acc++;
      end else begin
        PREADY = 1'b0;
        acc = 0;
      end
    end
  end

  // Response monitor: compare every handshaken response against the scoreboard.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge PCLK);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_extra", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          check("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
          check("rsp_err", 64'(rsp_err), 64'(e[32]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input int wn, input logic [DW-1:0] rd, input logic se, input int hold);
    logic mis, err_exp;
    logic [DW-1:0] r_exp, hr;
    logic he;
    int acc_exp, lat, n, p0, e0, s0;
    mis     = (addr[1:0] != 2'b00);
    acc_exp = (wn + 1 < TO) ? wn + 1 : TO;
    err_exp = mis || (wn >= TO) || se;
    r_exp   = (!wr && !err_exp) ? rd : '0;
    @(posedge PCLK); #1;
    wait_n = wn; slv_rdata = rd; slv_err = se;
    exp_paddr = addr; exp_pwrite = wr; exp_pwdata = wd;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
    rsp_ready = (hold == 0);
    p0 = psel_cnt; e0 = pen_cnt; s0 = stab_cnt;
    n = 0;
    @(negedge PCLK);
    while (!cmd_ready && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    check("accept", 64'(cmd_ready), 64'(1));
    sb.push_back({err_exp, r_exp});
    lat = 0;
    do begin
      @(posedge PCLK); #1;
      cmd_valid = (hold > 0);
      @(negedge PCLK);
      lat++;
    end while (!rsp_valid && lat < 40);
    check("latency", 64'(lat), mis ? 64'(1) : 64'(2 + acc_exp));
    if (hold > 0) begin
      hr = rsp_rdata; he = rsp_err;
      for (int i = 1; i < hold; i++) begin
        @(negedge PCLK);
        check("hold_valid", 64'(rsp_valid), 64'(1));
        check("hold_rdata", 64'(rsp_rdata), 64'(hr));
        check("hold_err", 64'(rsp_err), 64'(he));
        check("hold_ready", 64'(cmd_ready), 64'(0));
      end
      @(posedge PCLK); #1;
      rsp_ready = 1'b1;
      @(negedge PCLK);
      check("hs_ready", 64'(cmd_ready), 64'(0));
      @(posedge PCLK); #1;
      cmd_valid = 1'b0;
      @(negedge PCLK);
      check("ready_back", 64'(cmd_ready), 64'(1));
      check("valid_drop", 64'(rsp_valid), 64'(0));
    end
    check("psel_cycles", 64'(psel_cnt - p0), mis ? 64'(0) : 64'(1 + acc_exp));
    check("pen_cycles", 64'(pen_cnt - e0), mis ? 64'(0) : 64'(acc_exp));
    check("req_stable", 64'(stab_cnt - s0), 64'(0));
  endtask

  initial begin
    int n, seen;
    logic [AW-1:0] ra;
    logic rw;
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge PCLK);
    check("rst_psel", 64'(PSEL), 64'(0));
    check("rst_penable", 64'(PENABLE), 64'(0));
    check("rst_paddr", 64'(PADDR), 64'(0));
    check("rst_pwdata", 64'(PWDATA), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_rdata", 64'({rsp_err, rsp_rdata}), 64'(0));
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));

    do_cmd(1'b1, 13'h010, 32'hDEADBEEF, 0, 32'h0, 1'b0, 0);
    do_cmd(1'b0, 13'h024, 32'h0, 2, 32'h12345678, 1'b0, 0);
    do_cmd(1'b0, 13'h013, 32'h0, 0, 32'h55, 1'b0, 0);
    do_cmd(1'b0, 13'h030, 32'h0, 100, 32'h77, 1'b0, 0);
    do_cmd(1'b0, 13'h034, 32'h0, 3, 32'h0BADF00D, 1'b0, 0);
    do_cmd(1'b1, 13'h038, 32'h1, 3, 32'h0, 1'b1, 0);
    do_cmd(1'b0, 13'h040, 32'h0, 0, 32'hCAFE0001, 1'b0, 5);

    // Reset in the middle of ACCESS: transfer dropped, no response.
    @(posedge PCLK); #1;
    wait_n = 100; exp_paddr = 13'h050; exp_pwrite = 1'b0; exp_pwdata = 32'h0;
    cmd_write = 1'b0; cmd_addr = 13'h050; cmd_wdata = 32'h0; cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!PENABLE && n < 20);
    check("mid_access", 64'(PENABLE), 64'(1));
    cmd_valid = 1'b0;
    #2 PRESET = 1'b1;
    #1;
    check("async_psel", 64'(PSEL), 64'(0));
    check("async_penable", 64'(PENABLE), 64'(0));
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    check("post_rst_ready", 64'(cmd_ready), 64'(1));
    seen = 0;
    repeat (6) begin
      @(negedge PCLK);
      if (rsp_valid) seen++;
    end
    check("post_rst_no_rsp", 64'(seen), 64'(0));
    do_cmd(1'b0, 13'h044, 32'h0, 1, 32'hA5A50F0F, 1'b0, 0);

    for (int i = 0; i < 10; i++) begin
      ra = AW'($urandom);
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      rw = 1'($urandom);
      do_cmd(rw, ra, $urandom, int'($urandom_range(0, 5)), $urandom,
             rw ? 1'($urandom) : 1'b0, 0);
    end

    repeat (4) @(negedge PCLK);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
